call_stack: RTL and testbench

- Parametrised LIFO register stack holding return addresses for call/return instructions.
- Successor to the fixed-width load registers. Adds configurable width and depth, push/pop control, full/empty status, and sticky error flags.
- Sits beside the PC register in the datapath: the controller pushes PC+1 on a call and pops into the PC-source mux on a return.

---
 rtl/call_stack_pkg.sv | 43 ++++
 rtl/stack_ram.sv | 27 ++
 rtl/call_stack.sv | 133 +++++++++++++
 tb/tb_call_stack.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/call_stack_pkg.sv
// Shared types and width helpers for the return-address stack.
package call_stack_pkg;

    // Default geometry: entry width matches the PC, eight levels of nesting.
    localparam int CS_DEF_WIDTH = 12;
    localparam int CS_DEF_DEPTH = 8;

    // Operation selected for the current cycle.
    typedef enum logic [1:0] {
        STK_NOP,
        STK_PUSH,
        STK_POP,
        STK_REPLACE
    } stk_op_e;

    // Pointer width for a stack of the given depth (depth >= 2).
    function automatic int cs_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Count width: must be able to hold the value depth itself.
    function automatic int cs_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Push+pop on a non-empty stack is a replace of the top entry; push+pop on an
    // empty stack degenerates into a plain push. A pop on empty stays a POP so the
    // caller can flag underflow.
    function automatic stk_op_e decode_op(input logic push, input logic pop, input logic empty);
        stk_op_e op;
        if (push && pop && !empty) begin
            op = STK_REPLACE;
        end else if (push) begin
            op = STK_PUSH;
        end else if (pop) begin
            op = STK_POP;
        end else begin
            op = STK_NOP;
        end
        return op;
    endfunction

endpackage

// File: rtl/stack_ram.sv
// Entry storage for call_stack: one synchronous write port, one combinational
// read port. Contents are deliberately not reset; the owner masks stale data.
module stack_ram #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the addressed entry on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/call_stack.sv
// Parametrised LIFO of return addresses with full/empty status and sticky
// overflow/underflow flags. The write pointer always points at the next free
// slot; the top of stack lives one slot below it (modulo DEPTH).
module call_stack
    import call_stack_pkg::*;
#(
    parameter int WIDTH = CS_DEF_WIDTH,
    parameter int DEPTH = CS_DEF_DEPTH,
    parameter bit WRAP  = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           d,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           tos,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = cs_ptr_w(DEPTH);
    localparam int CNT_W = cs_cnt_w(DEPTH);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [PTR_W-1:0] wp_q, wp_d, wp_top;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             set_ovf, set_unf;
    logic             we;
    logic [PTR_W-1:0] waddr;
    logic [WIDTH-1:0] rd_data;
    stk_op_e          op;

    // Explicit wrap compares keep the pointer correct for non-power-of-2 DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_LAST : p - PTR_ONE;
    endfunction

    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_FULL);
    assign wp_top = ptr_dec(wp_q);
    assign op     = decode_op(push, pop, empty);

    // Next-state decode for pointer, count, storage write and error events.
    always_comb begin
        wp_d    = wp_q;
        count_d = count_q;
        we      = 1'b0;
        waddr   = wp_q;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        case (op)
            STK_PUSH: begin
                if (!full) begin
                    we      = 1'b1;
                    wp_d    = ptr_inc(wp_q);
                    count_d = count_q + CNT_ONE;
                end else if (WRAP) begin
                    // Circular overwrite: the oldest entry sits at wp, so it is lost.
                    we   = 1'b1;
                    wp_d = ptr_inc(wp_q);
                end else begin
                    set_ovf = 1'b1;
                end
            end
            STK_POP: begin
                if (!empty) begin
                    wp_d    = wp_top;
                    count_d = count_q - CNT_ONE;
                end else begin
                    set_unf = 1'b1;
                end
            end
            STK_REPLACE: begin
                // Return-then-call: overwrite the top in place, never an error.
                we    = 1'b1;
                waddr = wp_top;
            end
            default: begin
            end
        endcase
        // An error in the same cycle as clr_err wins over the clear.
        ovf_d = set_ovf | (ovf_q & ~clr_err);
        unf_d = set_unf | (unf_q & ~clr_err);
    end

    // Control state: pointer, occupancy and sticky flags, reset immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (d),
        .raddr (wp_top),
        .rdata (rd_data)
    );

    // Storage is never reset, so mask it while the stack holds nothing.
    assign tos       = empty ? '0 : rd_data;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack: three instances (DEPTH=4 reject, DEPTH=4 wrap,
// DEPTH=3 reject) share one stimulus stream and are each compared against a
// queue-based model of a return-address stack.
module tb_call_stack;

    localparam int NDUT = 3;
    localparam int DEP [NDUT] = '{4, 4, 3};
    localparam bit WRP [NDUT] = '{1'b0, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rst;
    logic        push, pop, clr_err;
    logic [11:0] d;

    logic [11:0] tos0, tos1, tos2;
    logic [2:0]  cnt0, cnt1;
    logic [1:0]  cnt2;
    logic        emp0, emp1, emp2, ful0, ful1, ful2;
    logic        ovf0, ovf1, ovf2, unf0, unf1, unf2;

    int total = 0;
    int bad   = 0;

    // Model state: queue back is the top of stack.
    logic [11:0] mq [NDUT][$];
    bit          mov [NDUT];
    bit          mun [NDUT];

    always #5 clk = ~clk;

    call_stack #(.WIDTH(12), .DEPTH(4), .WRAP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .d(d), .clr_err(clr_err),
        .tos(tos0), .count(cnt0), .empty(emp0), .full(ful0),
        .overflow(ovf0), .underflow(unf0));

    call_stack #(.WIDTH(12), .DEPTH(4), .WRAP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .d(d), .clr_err(clr_err),
        .tos(tos1), .count(cnt1), .empty(emp1), .full(ful1),
        .overflow(ovf1), .underflow(unf1));

    call_stack #(.WIDTH(12), .DEPTH(3), .WRAP(1'b0)) dut2 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .d(d), .clr_err(clr_err),
        .tos(tos2), .count(cnt2), .empty(emp2), .full(ful2),
        .overflow(ovf2), .underflow(unf2));

    task automatic chk(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            mq[k].delete();
            mov[k] = 1'b0;
            mun[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input logic p, input logic o,
                              input logic [11:0] dv, input logic c);
        bit so, su;
        so = 1'b0;
        su = 1'b0;
        if (p && o) begin
            if (mq[k].size() == 0) mq[k].push_back(dv);
            else mq[k][mq[k].size()-1] = dv;
        end else if (p) begin
            if (mq[k].size() < DEP[k]) begin
                mq[k].push_back(dv);
            end else if (WRP[k]) begin
                void'(mq[k].pop_front());
                mq[k].push_back(dv);
            end else begin
                so = 1'b1;
            end
        end else if (o) begin
            if (mq[k].size() > 0) void'(mq[k].pop_back());
            else su = 1'b1;
        end
        mov[k] = so | (mov[k] & !c);
        mun[k] = su | (mun[k] & !c);
    endtask

    task automatic check_dut(input int k);
        logic [11:0] t;
        int          c;
        logic        e, f, ov, un;
        int          n;
        case (k)
            0: begin t = tos0; c = int'(cnt0); e = emp0; f = ful0; ov = ovf0; un = unf0; end
            1: begin t = tos1; c = int'(cnt1); e = emp1; f = ful1; ov = ovf1; un = unf1; end
            default: begin t = tos2; c = int'(cnt2); e = emp2; f = ful2; ov = ovf2; un = unf2; end
        endcase
        n = mq[k].size();
        chk($sformatf("d%0d_tos", k), int'(t), (n == 0) ? 0 : int'(mq[k][n-1]));
        chk($sformatf("d%0d_count", k), c, n);
        chk($sformatf("d%0d_empty", k), int'(e), int'(n == 0));
        chk($sformatf("d%0d_full", k), int'(f), int'(n == DEP[k]));
        chk($sformatf("d%0d_overflow", k), int'(ov), int'(mov[k]));
        chk($sformatf("d%0d_underflow", k), int'(un), int'(mun[k]));
    endtask

    task automatic check_all();
        for (int k = 0; k < NDUT; k++) check_dut(k);
    endtask

    // Apply one cycle of stimulus, then compare just after the edge.
    task automatic step(input logic p, input logic o, input logic [11:0] dv, input logic c);
        @(negedge clk);
        push = p; pop = o; d = dv; clr_err = c;
        @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) model_step(k, p, o, dv, c);
        check_all();
    endtask

    // Assert reset between edges and check outputs before the next edge.
    task automatic hit_reset();
        @(negedge clk);
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill4();
        step(1, 0, 12'h010, 0);
        step(1, 0, 12'h020, 0);
        step(1, 0, 12'h030, 0);
        step(1, 0, 12'h040, 0);
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; d = '0;
        model_reset();
        #3;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 12'h000, 0);
        step(0, 0, 12'h000, 0);

        // Fill and drain.
        fill4();
        chk("fill_tos_d0", int'(tos0), 12'h040);
        chk("fill_full_d0", int'(ful0), 1);
        for (int i = 0; i < 4; i++) step(0, 1, 12'h000, 0);

        // Push while full, then pop, then clear errors.
        hit_reset();
        fill4();
        step(1, 0, 12'h050, 0);
        chk("ovf_tos_d0", int'(tos0), 12'h040);
        chk("wrap_tos_d1", int'(tos1), 12'h050);
        step(0, 1, 12'h000, 0);
        step(0, 0, 12'h000, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 12'h000, 0);

        // Underflow and set-over-clear.
        hit_reset();
        step(0, 1, 12'h000, 0);
        step(0, 1, 12'h000, 1);
        chk("unf_setwins_d0", int'(unf0), 1);
        step(0, 0, 12'h000, 1);

        // Simultaneous push+pop on a non-empty and an empty stack.
        step(1, 0, 12'h111, 0);
        step(1, 0, 12'h222, 0);
        step(1, 1, 12'h333, 0);
        step(0, 1, 12'h000, 0);
        step(0, 1, 12'h000, 0);
        step(1, 1, 12'h444, 0);
        chk("pp_empty_tos_d2", int'(tos2), 12'h444);

        // Replace while full and wrap the DEPTH=3 pointer several times.
        fill4();
        step(1, 1, 12'h5a5, 0);
        for (int i = 0; i < 7; i++) step(1, 1, 12'(12'h600 + i), 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 12'h000, 0);
            step(1, 0, 12'(12'h700 + i), 0);
            step(1, 0, 12'(12'h710 + i), 0);
        end

        // Mid-run reset with three entries held.
        hit_reset();
        step(1, 0, 12'h0a1, 0);
        step(1, 0, 12'h0a2, 0);
        step(1, 0, 12'h0a3, 0);
        hit_reset();
        chk("rst_mid_tos_d0", int'(tos0), 0);
        step(0, 0, 12'h000, 0);

        // Randomised traffic, alternating fill-biased and drain-biased phases.
        for (int i = 0; i < 600; i++) begin
            int  r, bias;
            logic p, o, c;
            bias = ((i / 60) % 2 == 0) ? 65 : 30;
            r = int'($urandom_range(0, 99));
            p = (r < bias);
            o = (int'($urandom_range(0, 99)) < (100 - bias)) || (r >= 95);
            c = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) hit_reset();
            else step(p, o, 12'($urandom), c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
